alu_scheduler: RTL
==================

// Module: alu_scheduler
// PURPOSE
//  Shares one N-bit ALU and its flag detector between two requesters.
//  Round-robin arbitration; each accepted op is sequenced IDLE->EXEC->RESP.
//  Operands and opcode are registered into the shared ALU; result and flags are captured.
//  Sits between the control units and the ALU/flag_detector pair.
// PARAMETERS
//  N   4   operand width; the ALU result is N+1 bits (bit N = carry)
// PORTS
//  clk            in   1     single system clock
//  rst_n          in   1     asynchronous active-low reset
//  req_valid      in   2     per-requester op request
//  req_ready      out  2     one-hot accept strobe; at most one bit high
//  req_a0/req_a1  in   N     operand A for requester 0/1
//  req_b0/req_b1  in   N     operand B for requester 0/1
//  req_sel0/1     in   4     ALU opcode (seleccion) for requester 0/1
//  alu_a          out  N     operand A to the shared ALU
//  alu_b          out  N     operand B to the shared ALU
//  alu_sel        out  4     opcode to the ALU and flag detector
//  alu_resultado  in   N+1   ALU result, combinational from alu_*
//  alu_flags      in   4     {Neg,Ovf,Carry,Zero} from the flag detector
//  rsp_valid      out  1     response available
//  rsp_ready      in   1     consumer accepts the response
//  rsp_id         out  1     requester index that owns the response
//  rsp_resultado  out  N+1   captured result
//  rsp_flags      out  4     captured flags
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, last_grant=1 so requester 0 wins first.
//  Reset is async and may assert mid-operation: the op is dropped and no response is issued.
//  IDLE: if any req_valid, compute grant:
//   - If only one requester is valid, it is granted.
//   - If both are valid, grant = ~last_grant.
//   - req_ready[grant]=1 combinationally, in that cycle only.
//   - On that edge: latch a/b/sel into the op regs, set rsp_id=grant,
//     set last_grant=grant, go to EXEC.
//  No req_valid in IDLE: req_ready=0 and the state is held.
//  alu_a/alu_b/alu_sel always drive the op regs and hold their last value outside EXEC.
//  EXEC (exactly 1 cycle): at the end of the cycle, capture alu_resultado and alu_flags
//  into rsp_resultado and rsp_flags, then go to RESP.
//  RESP: rsp_valid=1; rsp_id, rsp_resultado and rsp_flags stay stable.
//   - On rsp_valid & rsp_ready: go to IDLE; rsp_valid drops on the next cycle.
//   - A new grant is possible no earlier than the cycle after the handshake.
//  Latency: accept at edge k; rsp_valid is high from cycle k+2.
//  Maximum throughput is one op per 3 cycles.
//  Outside IDLE: req_ready=0, whatever req_valid does.
//  A requester may drop req_valid without penalty; no op is issued for it.
//  Widths: result is N+1 bits, zero-extended where needed; no truncation of bit N.
//  Opcodes are passed through unchecked; flag semantics belong to the flag detector.
//  Illegal state encodings return to IDLE.
// CONFIGURATION
//  FLAG_STICKY_EN defined: extra ports
//   - sticky_clr    in   1
//   - sticky_flags  out  2   {Ovf,Carry}
//  sticky_flags ORs in alu_flags[2:1] on every EXEC capture.
//  sticky_clr clears sticky_flags; a capture in the same cycle is ORed in after the clear.
//  sticky_flags resets to 0.
//  FLAG_STICKY_EN undefined: these ports and the register do not exist; behaviour is otherwise identical.
// TESTING
//  1 Reset: rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, all alu_* = 0.
//  2 Single op: req0 a=4'h7, b=4'h1, sel=0 at k; ALU model returns 5'h08 / flags 4'b0100
//    -> alu_a=7 and alu_b=1 in EXEC; rsp_valid at k+2; rsp_id=0; rsp_resultado=5'h08; rsp_flags=4'b0100.
//  3 Contention: req_valid=2'b11 held for 3 ops -> grants in the order 0,1,0; req_ready never 2'b11.
//  4 Backpressure: rsp_ready=0 for 5 cycles in RESP -> response held stable and no req_ready;
//    rsp_ready=1 -> IDLE on the next cycle.
//  5 Reset mid-op: rst_n pulsed low during EXEC -> rsp_valid stays 0, state is IDLE,
//    and the next grant goes to requester 0.
//  6 FLAG_STICKY_EN: op with carry, then op without -> sticky_flags=2'b01;
//    sticky_clr during the second capture with overflow -> 2'b10.

Source files
------------

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin scheduler sharing one ALU/flag detector between two requesters (optional FLAG_STICKY_EN)
module alu_scheduler #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_b1,
  input  logic [3:0]   req_sel0,
  input  logic [3:0]   req_sel1,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N:0]   alu_resultado,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N:0]   rsp_resultado,
  output logic [3:0]   rsp_flags
`ifdef FLAG_STICKY_EN
  ,
  input  logic         sticky_clr,
  output logic [1:0]   sticky_flags
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [N-1:0]   op_a_q, op_a_d;
  logic [N-1:0]   op_b_q, op_b_d;
  logic [3:0]     op_sel_q, op_sel_d;
  logic           rsp_id_q, rsp_id_d;
  logic [N:0]     rsp_res_q, rsp_res_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;
  logic           grant;
  logic [1:0]     ready_int;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end
  end

  // Next-state and datapath capture for the IDLE->EXEC->RESP sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;
    rsp_flags_d  = rsp_flags_q;
    ready_int    = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_int    = grant ? 2'b10 : 2'b01;
          op_a_d       = grant ? req_a1 : req_a0;
          op_b_d       = grant ? req_b1 : req_b0;
          op_sel_d     = grant ? req_sel1 : req_sel0;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d   = alu_resultado;
        rsp_flags_d = alu_flags;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, arbitration history, op registers and captured response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // Accept strobe is masked while reset is held so nothing is offered during reset
  assign req_ready     = rst_n ? ready_int : 2'b00;
  assign alu_a         = op_a_q;
  assign alu_b         = op_b_q;
  assign alu_sel       = op_sel_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_id        = rsp_id_q;
  assign rsp_resultado = rsp_res_q;
  assign rsp_flags     = rsp_flags_q;

`ifdef FLAG_STICKY_EN
  logic [1:0] sticky_q, sticky_d;

  // Clear first, then OR in {Ovf,Carry} from a capture happening this cycle
  always_comb begin
    sticky_d = sticky_clr ? 2'b00 : sticky_q;
    if (state_q == EXEC) begin
      sticky_d = sticky_d | alu_flags[2:1];
    end
  end

  // Sticky overflow/carry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule
